// File: rtl/glitch_seq_pkg.sv
// Shared types and helpers for the glitch/power stimulus sequencer.
// Holds the sequencer state encoding, phase-counter sizing and saturating arithmetic.
package glitch_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    PULSE = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // Wide enough to count 0 .. max(setup, pulse, hold).
  function automatic int phase_w(input int setup_c, input int pulse_c, input int hold_c);
    int m;
    m = setup_c;
    if (pulse_c > m) m = pulse_c;
    if (hold_c > m) m = hold_c;
    return $clog2(m + 1);
  endfunction

  // Callers size-cast in and out, so one function serves every counter width.
  function automatic logic [63:0] sat_inc(input logic [63:0] val,
                                          input logic [63:0] max_val,
                                          input logic        inc);
    return (inc && (val < max_val)) ? val + 64'd1 : val;
  endfunction

endpackage

// File: rtl/glitch_seq_toggle_cnt.sv
// Toggle monitor: registers obs, flags obs != obs_q while enabled, and keeps
// saturating per-step and running-total toggle counts.
module glitch_seq_toggle_cnt
  import glitch_seq_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int TOT_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             obs,
  input  logic             en,
  input  logic             step_clr,
  input  logic             total_clr,
  output logic [CNT_W-1:0] step_toggles,
  output logic [TOT_W-1:0] total_toggles
);

  localparam logic [63:0] STEP_MAX = (64'd1 << CNT_W) - 64'd1;
  localparam logic [63:0] TOT_MAX  = (64'd1 << TOT_W) - 64'd1;

  logic             r_obs_q;
  logic [CNT_W-1:0] r_step_cnt;
  logic [TOT_W-1:0] r_total_cnt;

  logic             w_toggle;
  logic [CNT_W-1:0] w_step_base;
  logic [CNT_W-1:0] w_step_next;
  logic [TOT_W-1:0] w_total_next;

  assign w_toggle     = en && (obs != r_obs_q);
  // step_clr marks the first cycle of a step, so that cycle counts from zero.
  assign w_step_base  = step_clr ? '0 : r_step_cnt;
  assign w_step_next  = CNT_W'(sat_inc(64'(w_step_base), STEP_MAX, w_toggle));
  assign w_total_next = TOT_W'(sat_inc(64'(r_total_cnt), TOT_MAX, w_toggle));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_obs_q     <= 1'b0;
      r_step_cnt  <= '0;
      r_total_cnt <= '0;
    end else begin
      r_obs_q     <= obs;
      r_step_cnt  <= w_step_next;
      r_total_cnt <= total_clr ? '0 : w_total_next;
    end
  end

  // Counts include the toggle seen in the current cycle, so the value shown
  // alongside step_valid already covers the step's final HOLD cycle.
  assign step_toggles  = w_step_next;
  assign total_toggles = w_total_next;

endmodule

// File: rtl/glitch_seq.sv
// Stimulus sequencer: sweeps static_out through every value with a
// setup / strobe-pulse / hold pattern per step, monitoring obs toggles.
module glitch_seq
  import glitch_seq_pkg::*;
#(
  parameter int STATIC_W     = 2,
  parameter int SETUP_CYCLES = 1,
  parameter int PULSE_CYCLES = 1,
  parameter int HOLD_CYCLES  = 1,
  parameter int CNT_W        = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      loop,
  input  logic                      obs,
  output logic [STATIC_W-1:0]       static_out,
  output logic                      strobe,
  output logic                      busy,
  output logic                      step_valid,
  output logic [CNT_W-1:0]          step_toggles,
  output logic [CNT_W+STATIC_W-1:0] total_toggles,
  output logic                      done
);

  localparam int PH_W = phase_w(SETUP_CYCLES, PULSE_CYCLES, HOLD_CYCLES);
  localparam logic [PH_W-1:0]     SETUP_LAST = PH_W'(SETUP_CYCLES - 1);
  localparam logic [PH_W-1:0]     PULSE_LAST = PH_W'(PULSE_CYCLES - 1);
  localparam logic [PH_W-1:0]     HOLD_LAST  = PH_W'(HOLD_CYCLES - 1);
  localparam logic [STATIC_W-1:0] STEP_LAST  = '1;

  state_t              r_state, w_state_next;
  logic [PH_W-1:0]     r_phase, w_phase_next;
  logic [STATIC_W-1:0] r_step, w_step_next;
  logic                r_strobe, r_busy, r_step_valid, r_done;
  logic                w_valid_next;

  always_comb begin
    w_state_next = r_state;
    w_phase_next = r_phase;
    w_step_next  = r_step;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next = SETUP;
          w_phase_next = '0;
          w_step_next  = '0;
        end
      end
      SETUP: begin
        if (r_phase == SETUP_LAST) begin
          w_state_next = PULSE;
          w_phase_next = '0;
        end else begin
          w_phase_next = r_phase + PH_W'(1);
        end
      end
      PULSE: begin
        if (r_phase == PULSE_LAST) begin
          w_state_next = HOLD;
          w_phase_next = '0;
        end else begin
          w_phase_next = r_phase + PH_W'(1);
        end
      end
      HOLD: begin
        if (r_phase == HOLD_LAST) begin
          w_phase_next = '0;
          if (r_step == STEP_LAST) begin
            // Without loop the step value is left on static_out while idle.
            w_state_next = loop ? SETUP : IDLE;
            w_step_next  = loop ? '0 : r_step;
          end else begin
            w_state_next = SETUP;
            w_step_next  = r_step + STATIC_W'(1);
          end
        end else begin
          w_phase_next = r_phase + PH_W'(1);
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign w_valid_next = (w_state_next == HOLD) && (w_phase_next == HOLD_LAST);

  // Outputs are registered from the next-state values so they line up with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_phase      <= '0;
      r_step       <= '0;
      r_strobe     <= 1'b0;
      r_busy       <= 1'b0;
      r_step_valid <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_phase      <= w_phase_next;
      r_step       <= w_step_next;
      r_strobe     <= (w_state_next == PULSE);
      r_busy       <= (w_state_next != IDLE);
      r_step_valid <= w_valid_next;
      r_done       <= w_valid_next && (w_step_next == STEP_LAST);
    end
  end

  glitch_seq_toggle_cnt #(
    .CNT_W(CNT_W),
    .TOT_W(CNT_W + STATIC_W)
  ) u_toggle_cnt (
    .clk          (clk),
    .rst          (rst),
    .obs          (obs),
    .en           (r_busy),
    .step_clr     ((r_state == SETUP) && (r_phase == '0)),
    .total_clr    ((r_state == IDLE) && start),
    .step_toggles (step_toggles),
    .total_toggles(total_toggles)
  );

  assign static_out = r_step;
  assign strobe     = r_strobe;
  assign busy       = r_busy;
  assign step_valid = r_step_valid;
  assign done       = r_done;

endmodule

// File: tb/tb_glitch_seq.sv
// Self-checking bench for glitch_seq: a sweep-offset reference model checks a
// default instance every cycle; a second instance exercises counter saturation.
module tb_glitch_seq;

  localparam int N    = 4;
  localparam int S    = 1;
  localparam int P    = 1;
  localparam int H    = 1;
  localparam int L    = S + P + H;
  localparam int CMAX = 255;
  localparam int TMAX = 1023;

  logic       clk = 1'b0;
  logic       rst = 1'b1, start = 1'b0, loop = 1'b0, obs = 1'b0;
  logic [1:0] static_out;
  logic       strobe, busy, step_valid, done;
  logic [7:0] step_toggles;
  logic [9:0] total_toggles;

  logic       start2 = 1'b0, loop2 = 1'b0, obs2 = 1'b0;
  logic [1:0] static_out2;
  logic       strobe2, busy2, step_valid2, done2;
  logic [1:0] step_toggles2;
  logic [3:0] total_toggles2;

  always #5 clk = ~clk;

  glitch_seq dut (
    .clk(clk), .rst(rst), .start(start), .loop(loop), .obs(obs),
    .static_out(static_out), .strobe(strobe), .busy(busy), .step_valid(step_valid),
    .step_toggles(step_toggles), .total_toggles(total_toggles), .done(done)
  );

  glitch_seq #(.STATIC_W(2), .SETUP_CYCLES(1), .PULSE_CYCLES(8), .HOLD_CYCLES(1), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .loop(loop2), .obs(obs2),
    .static_out(static_out2), .strobe(strobe2), .busy(busy2), .step_valid(step_valid2),
    .step_toggles(step_toggles2), .total_toggles(total_toggles2), .done(done2)
  );

  int checks = 0, errors = 0;
  int mode = 0;               // 0: obs=0, 1: obs=strobe&static_out[0], 2: random
  int m_busy = 0, m_t = 0, m_static = 0, m_step_cnt = 0, m_total = 0, obs_prev = 0;
  int ph = 0, tog = 0, done_cnt = 0;
  bit e_strobe, e_valid, e_done;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock: drive control inputs, step the model across the edge, drive obs, check.
  task automatic cyc(input logic r, input logic s, input logic lp);
    rst = r; start = s; loop = lp;
    @(posedge clk); #1;
    if (r) begin
      m_busy = 0; m_t = 0; m_static = 0; m_total = 0; m_step_cnt = 0; obs_prev = 0;
    end else begin
      obs_prev = int'(obs);
      if (m_busy == 0) begin
        if (s) begin m_busy = 1; m_t = 0; m_total = 0; end
      end else if (m_t == N * L - 1) begin
        if (lp) m_t = 0; else m_busy = 0;
      end else begin
        m_t++;
      end
    end
    if (m_busy != 0) m_static = m_t / L;
    ph       = m_t % L;
    e_strobe = (m_busy != 0) && ph >= S && ph < S + P;
    e_valid  = (m_busy != 0) && ph == L - 1;
    e_done   = e_valid && m_static == N - 1;
    case (mode)
      1:       obs = e_strobe && (m_static % 2 == 1);
      2:       obs = 1'($urandom % 2);
      default: obs = 1'b0;
    endcase
    obs2 = ~obs2;
    #1;
    tog = (m_busy != 0 && int'(obs) != obs_prev) ? 1 : 0;
    if (m_busy != 0 && ph == 0) m_step_cnt = 0;
    m_step_cnt = (m_step_cnt + tog > CMAX) ? CMAX : m_step_cnt + tog;
    m_total    = (m_total + tog > TMAX) ? TMAX : m_total + tog;
    chk("busy", busy, m_busy);
    chk("static_out", static_out, m_static);
    chk("strobe", strobe, e_strobe);
    chk("step_valid", step_valid, e_valid);
    chk("done", done, e_done);
    chk("total_toggles", total_toggles, m_total);
    if (e_valid) chk("step_toggles", step_toggles, m_step_cnt);
    if (done === 1'b1) done_cnt++;
  endtask

  logic [7:0] plan [4];
  int k, t;

  initial begin
    plan[0] = 8'd0; plan[1] = 8'd2; plan[2] = 8'd0; plan[3] = 8'd2;

    // Reset state
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    chk("rst_step_toggles", step_toggles, 0);
    cyc(0, 0, 0);

    // Plain sweep, obs idle
    mode = 0; done_cnt = 0;
    cyc(0, 1, 0);
    for (int i = 0; i < 14; i++) cyc(0, 0, 0);
    chk("sweep0_dones", done_cnt, 1);

    // obs = strobe & static_out[0]
    mode = 1; done_cnt = 0; k = 0;
    cyc(0, 1, 0);
    for (int i = 0; i < 14; i++) begin
      cyc(0, 0, 0);
      if (e_valid && k < 4) begin
        chk("plan_step_toggles", step_toggles, plan[k]);
        k++;
      end
    end
    chk("plan_total", total_toggles, 4);
    chk("plan_dones", done_cnt, 1);

    // Two looped sweeps, then stop
    done_cnt = 0;
    cyc(0, 1, 1);
    for (int i = 0; i < 17; i++) cyc(0, 0, 1);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0);
    chk("loop_dones", done_cnt, 2);
    chk("loop_total", total_toggles, 8);
    chk("loop_idle", busy, 0);

    // Reset during PULSE of step 2
    done_cnt = 0;
    cyc(0, 1, 0);
    for (int i = 0; i < 7; i++) cyc(0, 0, 0);
    chk("pre_rst_strobe", strobe, 1);
    cyc(1, 0, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_strobe", strobe, 0);
    chk("rst_mid_static", static_out, 0);
    cyc(0, 0, 0);
    chk("rst_mid_dones", done_cnt, 0);
    cyc(0, 1, 0);
    for (int i = 0; i < 13; i++) cyc(0, 0, 0);
    chk("post_rst_dones", done_cnt, 1);

    // Randomized control and obs
    mode = 2;
    for (int i = 0; i < 200; i++)
      cyc(1'($urandom % 50 == 0), 1'($urandom % 4 == 0), 1'($urandom % 2));
    cyc(1, 0, 0);
    cyc(0, 0, 0);

    // start held high: one sweep per IDLE entry
    mode = 0; done_cnt = 0;
    for (int i = 0; i < 39; i++) cyc(0, 1, 0);
    chk("held_start_dones", done_cnt, 3);
    for (int i = 0; i < 15; i++) cyc(0, 0, 0);

    // Saturation on the narrow-counter instance, obs2 toggling every cycle
    start2 = 1'b1;
    for (int c = 1; c <= 41; c++) begin
      cyc(0, 0, 0);
      start2 = 1'b0;
      t = c - 1;
      if (c <= 40) begin
        chk("sat_busy", busy2, 1);
        chk("sat_valid", step_valid2, (t % 10) == 9);
        chk("sat_step_toggles", step_toggles2, (t % 10 + 1 > 3) ? 3 : t % 10 + 1);
        chk("sat_total", total_toggles2, (t + 1 > 15) ? 15 : t + 1);
        chk("sat_done", done2, t == 39);
      end else begin
        chk("sat_idle", busy2, 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
